// File: rtl/mult_rr_scheduler.sv
// Round-robin scheduler sharing one 4x4 unsigned array multiplier between two requesters.
// Optional MULT_SCHED_STATS_EN adds per-ID completed-response counters (stat0_cnt/stat1_cnt).

module array_mult_structural (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic [7:0] o_p
);
    logic [4:0] w_acc;
    logic [4:0] w_nxt;
    logic [3:0] w_pp;
    logic       w_cy;
    logic       w_x;

    // Shift-add array: each row adds its AND-gate partial products to the previous
    // row shifted right, through a ripple chain of full adders.
    always_comb begin
        w_acc = {1'b0, i_a & {4{i_b[0]}}};
        w_nxt = '0;
        w_pp  = '0;
        w_cy  = 1'b0;
        w_x   = 1'b0;
        o_p   = '0;
        o_p[0] = w_acc[0];
        for (int i = 1; i < 4; i++) begin
            w_pp = i_a & {4{i_b[i]}};
            w_cy = 1'b0;
            for (int j = 0; j < 4; j++) begin
                w_x      = w_acc[j+1];
                w_nxt[j] = w_x ^ w_pp[j] ^ w_cy;
                w_cy     = (w_x & w_pp[j]) | (w_cy & (w_x ^ w_pp[j]));
            end
            w_nxt[4] = w_cy;
            w_acc    = w_nxt;
            o_p[i]   = w_acc[0];
        end
        o_p[7:4] = w_acc[4:1];
    end
endmodule

module mult_rr_scheduler #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_p,
    output logic       busy
`ifdef MULT_SCHED_STATS_EN
   ,output logic [7:0] stat0_cnt,
    output logic [7:0] stat1_cnt
`endif
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_RESP} state_t;

    localparam logic [2:0] SETTLE = 3'(SETTLE_CYCLES);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_rr_ptr;
    logic [3:0] r_m;
    logic [3:0] r_q;
    logic       r_id;
    logic [2:0] r_cnt;
    logic       r_rsp_valid;
    logic       r_rsp_id;
    logic [7:0] r_rsp_p;
    logic       w_gnt0;
    logic       w_gnt1;
    logic       w_capture;
    logic       w_rsp_hs;
    logic [7:0] w_prod;

    array_mult_structural u_mult (
        .i_a (r_m),
        .i_b (r_q),
        .o_p (w_prod)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Grants are gated by rst so no ready is shown while reset is held.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_capture   = 1'b0;
        w_rsp_hs    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_gnt0 = ~rst & req0_valid & (~req1_valid | ~r_rr_ptr);
                w_gnt1 = ~rst & req1_valid & (~req0_valid |  r_rr_ptr);
                if (w_gnt0 || w_gnt1) w_state_nxt = S_CALC;
            end
            S_CALC: begin
                if (r_cnt == 3'd1) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (r_rsp_valid && rsp_ready) begin
                    w_rsp_hs    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr    <= 1'b0;
            r_m         <= '0;
            r_q         <= '0;
            r_id        <= 1'b0;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_p     <= '0;
        end else begin
            if (w_gnt0 || w_gnt1) begin
                r_m   <= w_gnt1 ? req1_a : req0_a;
                r_q   <= w_gnt1 ? req1_b : req0_b;
                r_id  <= w_gnt1;
                r_cnt <= SETTLE;
            end else if (r_state == S_CALC) begin
                r_cnt <= r_cnt - 3'd1;
            end
            if (w_capture) begin
                r_rsp_p     <= w_prod;
                r_rsp_id    <= r_id;
                r_rsp_valid <= 1'b1;
            end else if (w_rsp_hs) begin
                // Hand priority to the other requester even if it was idle.
                r_rsp_valid <= 1'b0;
                r_rr_ptr    <= ~r_rsp_id;
            end
        end
    end

`ifdef MULT_SCHED_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat0_cnt <= '0;
            stat1_cnt <= '0;
        end else if (w_rsp_hs) begin
            if (r_rsp_id) stat1_cnt <= stat1_cnt + 8'd1;
            else          stat0_cnt <= stat0_cnt + 8'd1;
        end
    end
`endif

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_p      = r_rsp_p;
    assign busy       = (r_state != S_IDLE);
endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Directed bench for mult_rr_scheduler: one instance with SETTLE_CYCLES=1, one with 4, shared inputs.
module tb_mult_rr_scheduler;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b0;
    logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic       r0_rdy1, r1_rdy1, vld1, id1, busy1;
    logic       r0_rdy4, r1_rdy4, vld4, id4, busy4;
    logic [7:0] p1, p4;
`ifdef MULT_SCHED_STATS_EN
    logic [7:0] s0_1, s1_1, s0_4, s1_4;
`endif
    int total = 0;
    int bad   = 0;
    int n;
    logic seen;

    typedef struct {
        logic       v0;
        logic [3:0] a0, b0;
        logic       v1;
        logic [3:0] a1, b1;
        logic       eid;
        logic [7:0] ep;
    } vec_t;
    vec_t tbl [9];

    always #5 clk = ~clk;

    mult_rr_scheduler #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(r0_rdy1), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(r1_rdy1), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(vld1), .rsp_ready(rsp_ready), .rsp_id(id1), .rsp_p(p1), .busy(busy1)
`ifdef MULT_SCHED_STATS_EN
       ,.stat0_cnt(s0_1), .stat1_cnt(s1_1)
`endif
    );

    mult_rr_scheduler #(.SETTLE_CYCLES(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(r0_rdy4), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(r1_rdy4), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(vld4), .rsp_ready(rsp_ready), .rsp_id(id4), .rsp_p(p4), .busy(busy4)
`ifdef MULT_SCHED_STATS_EN
       ,.stat0_cnt(s0_4), .stat1_cnt(s1_4)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 4'd3,  4'd5,  1'b1, 4'd15, 4'd15, 1'b0, 8'd15};
        tbl[1] = '{1'b1, 4'd3,  4'd5,  1'b1, 4'd15, 4'd15, 1'b1, 8'd225};
        tbl[2] = '{1'b1, 4'd2,  4'd2,  1'b1, 4'd4,  4'd4,  1'b0, 8'd4};
        tbl[3] = '{1'b1, 4'd2,  4'd2,  1'b1, 4'd4,  4'd4,  1'b1, 8'd16};
        tbl[4] = '{1'b0, 4'd1,  4'd1,  1'b1, 4'd9,  4'd9,  1'b1, 8'd81};
        tbl[5] = '{1'b1, 4'd13, 4'd11, 1'b1, 4'd6,  4'd7,  1'b0, 8'd143};
        tbl[6] = '{1'b1, 4'd0,  4'd15, 1'b0, 4'd3,  4'd3,  1'b0, 8'd0};
        tbl[7] = '{1'b1, 4'd1,  4'd1,  1'b1, 4'd15, 4'd14, 1'b1, 8'd210};
        tbl[8] = '{1'b1, 4'd15, 4'd15, 1'b0, 4'd2,  4'd2,  1'b0, 8'd225};

        // Reset held while inputs toggle.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req0_valid = i[0];
            req1_valid = 1'b1;
            req0_a = 4'(i + 3); req0_b = 4'd7;
            rsp_ready = i[1];
            #1;
            chk("rst_rdy0", r0_rdy1, 0);
            chk("rst_rdy1", r1_rdy1, 0);
            chk("rst_vld", vld1, 0);
            chk("rst_busy", busy1, 0);
            chk("rst_p", p1, 0);
            chk("rst_vld4", vld4, 0);
        end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b0;

        // Table: arbitration, product and exact SETTLE=1 timing.
        for (int r = 0; r < 9; r++) begin
            req0_valid = tbl[r].v0; req0_a = tbl[r].a0; req0_b = tbl[r].b0;
            req1_valid = tbl[r].v1; req1_a = tbl[r].a1; req1_b = tbl[r].b1;
            rsp_ready  = 1'b1;
            #1;
            chk($sformatf("row%0d_rdy0", r), r0_rdy1, tbl[r].eid == 1'b0);
            chk($sformatf("row%0d_rdy1", r), r1_rdy1, tbl[r].eid == 1'b1);
            @(posedge clk); #1;
            req0_valid = 1'b0; req1_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("row%0d_calc_busy", r), busy1, 1);
            chk($sformatf("row%0d_calc_vld", r), vld1, 0);
            @(negedge clk);
            chk($sformatf("row%0d_vld", r), vld1, 1);
            chk($sformatf("row%0d_id", r), id1, tbl[r].eid);
            chk($sformatf("row%0d_p", r), p1, tbl[r].ep);
            @(negedge clk);
            chk($sformatf("row%0d_done_vld", r), vld1, 0);
            chk($sformatf("row%0d_done_busy", r), busy1, 0);
        end

        // Backpressure with both valids held; rr_ptr=1 here so req1 wins.
        req0_valid = 1'b1; req0_a = 4'd9; req0_b = 4'd9;
        req1_valid = 1'b1; req1_a = 4'd5; req1_b = 4'd6;
        rsp_ready  = 1'b0;
        #1;
        chk("bp_rdy1", r1_rdy1, 1);
        chk("bp_rdy0", r0_rdy1, 0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_vld", i), vld1, 1);
            chk($sformatf("bp%0d_p", i), p1, 30);
            chk($sformatf("bp%0d_id", i), id1, 1);
            chk($sformatf("bp%0d_rdy", i), {r0_rdy1, r1_rdy1}, 0);
            chk($sformatf("bp%0d_busy", i), busy1, 1);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_end_vld", vld1, 0);
        chk("bp_end_busy", busy1, 0);
        chk("bp_next_rdy0", r0_rdy1, 1);
        chk("bp_next_rdy1", r1_rdy1, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Asynchronous reset while in RESP clears outputs without a clock edge.
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd3;
        @(negedge clk);
        @(negedge clk);
        chk("ar_pre_vld", vld1, 1);
        chk("ar_pre_p", p1, 6);
        #2 rst = 1'b1;
        #1;
        chk("ar_vld", vld1, 0);
        chk("ar_busy", busy1, 0);
        chk("ar_p", p1, 0);
        chk("ar_rdy0", r0_rdy1, 0);
        req0_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // SETTLE_CYCLES=4: req1 7*9 accepted at edge k, response exactly at edge k+4.
        req1_valid = 1'b1; req1_a = 4'd7; req1_b = 4'd9;
        rsp_ready = 1'b1;
        #1;
        chk("lat_rdy1", r1_rdy4, 1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("lat_k%0d_vld", i), vld4, i == 4);
            if (i < 4) chk($sformatf("lat_k%0d_busy", i), busy4, 1);
        end
        chk("lat_p", p4, 63);
        chk("lat_id", id4, 1);
        @(negedge clk);
        chk("lat_done_busy", busy4, 0);

        // req0 served alone moves rr_ptr to 1; a reset in CALC must bring it back to 0.
        req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd2;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        repeat (6) @(negedge clk);
        req1_valid = 1'b1; req1_a = 4'd4; req1_b = 4'd4;
        #1;
        chk("rc_rdy1", r1_rdy4, 1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        @(negedge clk);
        chk("rc_busy", busy4, 1);
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (vld4) seen = 1'b1;
        end
        chk("rc_no_rsp", seen, 0);
        chk("rc_busy_after", busy4, 0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("rc_rr_rdy0", r0_rdy4, 1);
        chk("rc_rr_rdy1", r1_rdy4, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;

`ifdef MULT_SCHED_STATS_EN
        // 300 completed req1 operations wrap stat1_cnt to 44.
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("st_rst0", s0_1, 0);
        chk("st_rst1", s1_1, 0);
        @(negedge clk);
        rst = 1'b0;
        req1_valid = 1'b1; req1_a = 4'd5; req1_b = 4'd5;
        rsp_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 2000 && n < 300; c++) begin
            @(negedge clk);
            if (vld1) n++;
            if (n == 300) req1_valid = 1'b0;
        end
        req1_valid = 1'b0;
        chk("st_ops_done", n, 300);
        @(negedge clk);
        chk("st_cnt1", s1_1, 44);
        chk("st_cnt0", s0_1, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mult_rr_scheduler.md
Name: mult_rr_scheduler

Overview:
Shares one 4x4 unsigned array multiplier (array_mult_structural, instantiated inside this block) between two requesters. Requesters use valid/ready handshakes and are granted by round-robin arbitration. Operands are registered before the multiplier. After a programmable settle time the product is captured, then returned on a single response channel tagged with the requester ID. This block sits between the tt09 top-level I/O glue and the multiplier datapath.

Parameters:
SETTLE_CYCLES, 1, cycles spent in CALC before the product is captured; legal range 1..7.

Ports:
clk  input  1  system clock; everything is rising-edge.
rst  input  1  asynchronous, active-high reset.
req0_valid  input  1  requester 0 has an operand pair.
req0_ready  output  1  requester 0 pair accepted this cycle.
req0_a  input  4  requester 0 multiplicand.
req0_b  input  4  requester 0 multiplier.
req1_valid  input  1  requester 1 has an operand pair.
req1_ready  output  1  requester 1 pair accepted this cycle.
req1_a  input  4  requester 1 multiplicand.
req1_b  input  4  requester 1 multiplier.
rsp_valid  output  1  result available.
rsp_ready  input  1  consumer takes the result.
rsp_id  output  1  requester that owns rsp_p.
rsp_p  output  8  unsigned product a*b.
busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (async assert, sampled release):
  - state=IDLE, rr_ptr=0.
  - Operand registers, rsp_p, rsp_id and counter are cleared to 0.
  - rsp_valid=0, req*_ready=0, busy=0.
- States: IDLE, CALC, RESP.
- IDLE:
  - Grant is combinational from the valids.
  - Only one valid → that requester wins.
  - Both valid → the requester named by rr_ptr wins.
  - The winner's ready is high that cycle; the other ready stays low. At most one ready is ever high.
  - Handshake edge (valid&ready): capture a→m_reg, b→q_reg, id→id_reg; counter=SETTLE_CYCLES; go to CALC.
  - No valid → stay in IDLE.
  - A valid dropped before its grant is simply not served; nothing is sticky.
- CALC:
  - Both readys are low; the counter decrements each cycle.
  - The multiplier is driven only from m_reg/q_reg.
  - On the cycle the counter equals 1: rsp_p ← product, rsp_id ← id_reg, rsp_valid ← 1; go to RESP.
- RESP:
  - rsp_valid, rsp_p and rsp_id are held stable until rsp_ready.
  - Handshake edge: rsp_valid←0, rr_ptr←~rsp_id, go to IDLE.
  - rsp_ready while rsp_valid=0 has no effect.
- Latency: accept at edge k → rsp_valid high after edge k+SETTLE_CYCLES.
- Throughput: at most one operation per SETTLE_CYCLES+2 cycles (IDLE and RESP each take at least one cycle).
- Arithmetic: 8-bit unsigned product; maximum 15*15=225, so no overflow or truncation.
- Fairness: back-to-back contention alternates 0,1,0,1. A requester served alone still moves rr_ptr to the other requester.
- Reset mid-operation (CALC or RESP): the operation is discarded, no response is issued, and rr_ptr returns to 0.
- Requesters must hold a and b stable while valid is high. Operands are sampled only on the handshake edge.

Optional Feature:
MULT_SCHED_STATS_EN
- Defined:
  - Adds outputs stat0_cnt[7:0] and stat1_cnt[7:0].
  - Each counts completed response handshakes for its ID, wrapping 255→0.
  - Both are cleared by rst.
  - Counters increment on the rsp_valid&rsp_ready edge only.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst high while toggling inputs → rsp_valid=0, req0_ready=req1_ready=0, busy=0, rsp_p=0. Assert rst asynchronously mid-cycle → outputs clear without a clock edge.
- Single request, SETTLE_CYCLES=1, rsp_ready=1: req0 a=13, b=11 → req0_ready for one cycle, then rsp_valid one edge later with rsp_p=143, rsp_id=0, busy low again after the handshake.
- Contention after reset: req0 3*5 and req1 15*15 both held valid → responses (id0, 15) then (id1, 225). A third simultaneous pair (2*2, 4*4) → id0 served first (rr_ptr=0 again).
- Backpressure: rsp_ready=0 for 5 cycles with both valids high → rsp_valid, rsp_p and rsp_id stable, both readys low, busy=1. The response completes on the first rsp_ready=1.
- Latency parameter: SETTLE_CYCLES=4, req1 7*9 accepted at edge k → rsp_valid rises exactly at edge k+4 with rsp_p=63. Pulse rst during CALC → no rsp_valid ever rises for that operation.
- Stats (MULT_SCHED_STATS_EN defined): 300 completed req1 operations → stat1_cnt=44, stat0_cnt=0.
